// File: rtl/rect_finder_pkg.sv
// rect_pkg: shared types and helpers for the rectangle finder and the
// corner-flip consumer.
//   - DEF_ROWS / DEF_COLS : default matrix geometry
//   - rf_state_e          : search FSM states
//   - bit_idx()           : flat bit position of element (r,c); (0,0) is the MSB
//   - num_pairs()         : number of row pairs scanned, rows*(rows-1)/2
package rect_pkg;

  localparam int unsigned DEF_ROWS = 4;
  localparam int unsigned DEF_COLS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } rf_state_e;

  function automatic int unsigned bit_idx(input int unsigned rows,
                                          input int unsigned cols,
                                          input int unsigned r,
                                          input int unsigned c);
    return (rows * cols - 1) - (r * cols + c);
  endfunction

  function automatic int unsigned num_pairs(input int unsigned rows);
    return rows * (rows - 1) / 2;
  endfunction

endpackage

// File: rtl/rect_finder_col_pair_pick.sv
// col_pair_pick: combinational picker over the AND of two matrix rows.
//   row_and_i : bit c = column c common to both rows
//   hit_o     : two or more common columns
//   c1_o      : lowest common column
//   c2_o      : second lowest common column
module col_pair_pick #(
  parameter int unsigned COLS = 4,
  parameter int unsigned CW   = 2
) (
  input  logic [COLS-1:0] row_and_i,
  output logic            hit_o,
  output logic [CW-1:0]   c1_o,
  output logic [CW-1:0]   c2_o
);

  logic have1;
  logic have2;

  always_comb begin
    have1 = 1'b0;
    have2 = 1'b0;
    c1_o  = '0;
    c2_o  = '0;
    for (int unsigned i = 0; i < COLS; i++) begin
      if (row_and_i[i]) begin
        if (!have1) begin
          c1_o  = CW'(i);
          have1 = 1'b1;
        end else if (!have2) begin
          c2_o  = CW'(i);
          have2 = 1'b1;
        end
      end
    end
    hit_o = have2;
  end

endmodule

// File: rtl/rect_finder.sv
// rect_finder: sequential search for four 1-bits forming a rectangle in a
// ROWS x COLS matrix, one row pair per clock, first hit in (r1, r2) order.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : request a search (sampled only in IDLE)
//   m_in            : matrix, element (r,c) at bit (ROWS*COLS-1)-(r*COLS+c)
//   busy            : high while scanning
//   done            : one-cycle completion pulse
//   found           : rectangle found (valid with done, held until next start)
//   r1, r2, c1, c2  : corner coordinates, r1 < r2, c1 < c2
//   m_out           : only with RECT_FINDER_FLIP_EN; latched matrix with the
//                     four corners inverted on a hit
module rect_finder
  import rect_pkg::*;
#(
  parameter int unsigned ROWS = DEF_ROWS,
  parameter int unsigned COLS = DEF_COLS,
  localparam int unsigned RW = (ROWS > 2) ? $clog2(ROWS) : 1,
  localparam int unsigned CW = (COLS > 2) ? $clog2(COLS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ROWS*COLS-1:0] m_in,
  output logic                 busy,
  output logic                 done,
  output logic                 found,
  output logic [RW-1:0]        r1,
  output logic [RW-1:0]        r2,
  output logic [CW-1:0]        c1,
  output logic [CW-1:0]        c2
`ifdef RECT_FINDER_FLIP_EN
  ,
  output logic [ROWS*COLS-1:0] m_out
`endif
);

  localparam int unsigned MW = (ROWS * COLS > 2) ? $clog2(ROWS * COLS) : 1;

  rf_state_e            state_q, state_d;
  logic [ROWS*COLS-1:0] m_q, m_d;
  logic [RW-1:0]        pr1_q, pr1_d, pr2_q, pr2_d;
  logic                 found_q, found_d;
  logic [RW-1:0]        r1_q, r1_d, r2_q, r2_d;
  logic [CW-1:0]        c1_q, c1_d, c2_q, c2_d;

  logic [COLS-1:0]      row_and;
  logic                 hit;
  logic [CW-1:0]        pc1, pc2;

  always_comb begin
    row_and = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      row_and[c] = m_q[MW'(bit_idx(ROWS, COLS, 32'(pr1_q), c))]
                 & m_q[MW'(bit_idx(ROWS, COLS, 32'(pr2_q), c))];
    end
  end

  col_pair_pick #(
    .COLS (COLS),
    .CW   (CW)
  ) u_pick (
    .row_and_i (row_and),
    .hit_o     (hit),
    .c1_o      (pc1),
    .c2_o      (pc2)
  );

`ifdef RECT_FINDER_FLIP_EN
  logic [ROWS*COLS-1:0] m_out_q, m_out_d;
  logic [ROWS*COLS-1:0] corner_mask;

  always_comb begin
    corner_mask = '0;
    corner_mask[MW'(bit_idx(ROWS, COLS, 32'(pr1_q), 32'(pc1)))] = 1'b1;
    corner_mask[MW'(bit_idx(ROWS, COLS, 32'(pr1_q), 32'(pc2)))] = 1'b1;
    corner_mask[MW'(bit_idx(ROWS, COLS, 32'(pr2_q), 32'(pc1)))] = 1'b1;
    corner_mask[MW'(bit_idx(ROWS, COLS, 32'(pr2_q), 32'(pc2)))] = 1'b1;
  end

  assign m_out = m_out_q;
`endif

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    pr1_d   = pr1_q;
    pr2_d   = pr2_q;
    found_d = found_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    c1_d    = c1_q;
    c2_d    = c2_q;
`ifdef RECT_FINDER_FLIP_EN
    m_out_d = m_out_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = m_in;
          pr1_d   = '0;
          pr2_d   = RW'(1);
          found_d = 1'b0;
          r1_d    = '0;
          r2_d    = '0;
          c1_d    = '0;
          c2_d    = '0;
`ifdef RECT_FINDER_FLIP_EN
          m_out_d = '0;
`endif
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (hit) begin
          found_d = 1'b1;
          r1_d    = pr1_q;
          r2_d    = pr2_q;
          c1_d    = pc1;
          c2_d    = pc2;
`ifdef RECT_FINDER_FLIP_EN
          m_out_d = m_q ^ corner_mask;
`endif
          state_d = DONE;
        end else if (pr2_q == RW'(ROWS - 1)) begin
          if (pr1_q == RW'(ROWS - 2)) begin
            // Last pair missed: coordinates were already cleared on start.
            found_d = 1'b0;
`ifdef RECT_FINDER_FLIP_EN
            m_out_d = m_q;
`endif
            state_d = DONE;
          end else begin
            pr1_d = pr1_q + RW'(1);
            pr2_d = pr1_q + RW'(2);
          end
        end else begin
          pr2_d = pr2_q + RW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      pr1_q   <= '0;
      pr2_q   <= '0;
      found_q <= 1'b0;
      r1_q    <= '0;
      r2_q    <= '0;
      c1_q    <= '0;
      c2_q    <= '0;
`ifdef RECT_FINDER_FLIP_EN
      m_out_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      pr1_q   <= pr1_d;
      pr2_q   <= pr2_d;
      found_q <= found_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
`ifdef RECT_FINDER_FLIP_EN
      m_out_q <= m_out_d;
`endif
    end
  end

  assign busy  = (state_q == SCAN);
  assign done  = (state_q == DONE);
  assign found = found_q;
  assign r1    = r1_q;
  assign r2    = r2_q;
  assign c1    = c1_q;
  assign c2    = c2_q;

endmodule

// File: tb/tb_rect_finder.sv
// Bench for rect_finder at default 4x4 geometry, checked against a
// brute-force search over all row pairs and column sets.
module tb_rect_finder;
  import rect_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] m_in;
  logic        busy, done, found;
  logic [1:0]  r1, r2, c1, c2;
`ifdef RECT_FINDER_FLIP_EN
  logic [15:0] m_out;
`endif

  int tests = 0;
  int fails = 0;

  rect_finder #(.ROWS(4), .COLS(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .m_in  (m_in),
    .busy  (busy),
    .done  (done),
    .found (found),
    .r1    (r1),
    .r2    (r2),
    .c1    (c1),
    .c2    (c2)
`ifdef RECT_FINDER_FLIP_EN
    ,
    .m_out (m_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit elem(input logic [15:0] m, input int r, input int c);
    return m[15 - (r * 4 + c)];
  endfunction

  // Exhaustive reference: first rectangle in (r1, r2) order, plus the
  // number of edges from start acceptance to done.
  task automatic model(input logic [15:0] m, output bit f, output int a, output int b,
                       output int x, output int y, output int cyc, output logic [15:0] mo);
    int k, cnt, cx, cy;
    f = 0; a = 0; b = 0; x = 0; y = 0; k = 0; mo = m;
    cyc = int'(num_pairs(4));
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++) begin
        if (!f) begin
          cnt = 0; cx = 0; cy = 0;
          for (int c = 0; c < 4; c++)
            if (elem(m, i, c) && elem(m, j, c)) begin
              if (cnt == 0) cx = c;
              else if (cnt == 1) cy = c;
              cnt++;
            end
          if (cnt >= 2) begin
            f = 1; a = i; b = j; x = cx; y = cy; cyc = k + 1;
            mo = m;
            mo[15 - (i * 4 + cx)] = ~mo[15 - (i * 4 + cx)];
            mo[15 - (i * 4 + cy)] = ~mo[15 - (i * 4 + cy)];
            mo[15 - (j * 4 + cx)] = ~mo[15 - (j * 4 + cx)];
            mo[15 - (j * 4 + cy)] = ~mo[15 - (j * 4 + cy)];
          end
          k++;
        end
      end
  endtask

  task automatic check_result(input string tag, input logic [15:0] m, input int n);
    bit ef; int ea, eb, ex, ey, ecyc; logic [15:0] emo;
    model(m, ef, ea, eb, ex, ey, ecyc, emo);
    check({tag, "_latency"}, n, ecyc);
    check({tag, "_done"}, done, 1);
    check({tag, "_found"}, found, ef);
    check({tag, "_coords"}, {r1, r2, c1, c2}, {2'(ea), 2'(eb), 2'(ex), 2'(ey)});
`ifdef RECT_FINDER_FLIP_EN
    check({tag, "_m_out"}, m_out, emo);
`endif
  endtask

  // Drives start at a negedge; the following posedge is edge t.
  task automatic search(input string tag, input logic [15:0] m);
    int n;
    @(negedge clk); start = 1'b1; m_in = m;
    @(posedge clk); #1; start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_cleared"}, found, 0);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check_result(tag, m, n);
    @(posedge clk); #1;
    check({tag, "_done_drop"}, done, 0);
  endtask

  initial begin
    int n;
    logic [15:0] rm;
    rst = 1'b1; start = 1'b0; m_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_found", found, 0);
    check("rst_coords", {r1, r2, c1, c2}, 0);
    @(negedge clk); rst = 1'b0;

    search("m9009", 16'h9009);
    check("m9009_hold_found", found, 1);
    check("m9009_const_coords", {r1, r2, c1, c2}, {2'd0, 2'd3, 2'd0, 2'd3});
    repeat (3) @(posedge clk);
    #1;
    check("m9009_held", {found, r1, r2, c1, c2}, {1'b1, 2'd0, 2'd3, 2'd0, 2'd3});

    search("mFFFF", 16'hFFFF);
`ifdef RECT_FINDER_FLIP_EN
    check("mFFFF_const_m_out", m_out, 16'h33FF);
`endif
    search("m0000", 16'h0000);
    search("m8888", 16'h8888);
    search("m0660", 16'h0660);

    // start and m_in changes during a search are ignored
    @(negedge clk); start = 1'b1; m_in = 16'h0000;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); @(negedge clk); start = 1'b1; m_in = 16'hFFFF;
    @(posedge clk); #1; start = 1'b0;
    n = 2;
    while (!done && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check_result("ignore", 16'h0000, n);

    // reset mid-scan aborts without a done pulse
    @(posedge clk);
    @(negedge clk); start = 1'b1; m_in = 16'h0000;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", busy, 0);
    check("abort_outs", {done, found, r1, r2, c1, c2}, 0);
    @(negedge clk); rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      check("abort_no_done", done, 0);
    end
    search("after_abort", 16'h9009);

    for (int i = 0; i < 24; i++) begin
      rm = 16'($urandom) & 16'($urandom);
      if (i % 3 == 0) rm = rm | 16'($urandom);
      search($sformatf("rand%0d", i), rm);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
